// File: rtl/fila_entrada_proc_pkg.sv
// Shared definitions for the local-node input buffer stage (fila_entrada_proc).
// Holds the default flit width, the processed-flag bit index, the pacing FSM
// encoding and a ceil-log2 helper for sizing pointers and counters.
package fila_entrada_proc_pkg;

  localparam int unsigned FLIT_W_DEF    = 14;
  localparam int unsigned PROC_FLAG_BIT = FLIT_W_DEF - 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } estado_t;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fila_entrada_proc_fifo_sincrona.sv
// Synchronous FIFO: DEPTH x W register array, wrapping pointers, occupancy count.
// Ports: clk, rst (sync, active-high), push/wdata (write, caller guarantees not full),
// pop (read, caller guarantees not empty), rdata_c (current head, combinational),
// full_c/empty_c (combinational compares on the registered count).
module fila_entrada_proc_fifo_sincrona
  import fila_entrada_proc_pkg::*;
#(
  parameter int unsigned W     = FLIT_W_DEF,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata_c,
  output logic         full_c,
  output logic         empty_c
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Storage is not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata_c = mem[rd_ptr];
  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);

endmodule

// File: rtl/fila_entrada_proc.sv
// Input-side buffer in front of the local flit processor. Buffers flits from the
// router local port and releases them as single-cycle wr_en_out/data_out pulses
// spaced by GAP idle cycles, returning one credit per released flit.
// Ports: clk, rst (sync, active-high), wr_en_in/data_in (upstream flit),
// full (FIFO at DEPTH), overflow (sticky: write while full), credit_out,
// wr_en_out/data_out (registered strobe and flit to the processor).
// Build option FILA_FILTRO_PROCESSADO_EN: flits with the processed flag set are
// dropped on arrival and credited at once; credit_out becomes {filter, release}.
module fila_entrada_proc
  import fila_entrada_proc_pkg::*;
#(
  parameter int unsigned FLIT_W = FLIT_W_DEF,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned GAP    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_in,
  input  logic [FLIT_W-1:0] data_in,
  output logic              full,
  output logic              overflow,
`ifdef FILA_FILTRO_PROCESSADO_EN
  output logic [1:0]        credit_out,
`else
  output logic              credit_out,
`endif
  output logic              wr_en_out,
  output logic [FLIT_W-1:0] data_out
);

  localparam int unsigned GAP_W = (GAP > 1) ? clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  estado_t           state;
  logic [GAP_W-1:0]  gap_cnt;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [FLIT_W-1:0] head;

`ifdef FILA_FILTRO_PROCESSADO_EN
  localparam int unsigned FLAG_BIT = FLIT_W - FLIT_W_DEF + PROC_FLAG_BIT;
  logic filt;
  // Processed flits never occupy a slot, so they are neither stored nor overflow.
  assign filt = wr_en_in && data_in[FLAG_BIT];
  assign push = wr_en_in && !filt && !full;
`else
  assign push = wr_en_in && !full;
`endif

  // Release only from IDLE; pop reads the pre-edge head.
  assign pop = (state == ST_IDLE) && !fifo_empty;

  fila_entrada_proc_fifo_sincrona #(
    .W     (FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wdata   (data_in),
    .pop     (pop),
    .rdata_c (head),
    .full_c  (full),
    .empty_c (fifo_empty)
  );

  // Pacing FSM, release/credit strobes and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      gap_cnt    <= '0;
      wr_en_out  <= 1'b0;
      data_out   <= '0;
      credit_out <= '0;
      overflow   <= 1'b0;
    end else begin
      wr_en_out <= pop;
`ifdef FILA_FILTRO_PROCESSADO_EN
      credit_out <= {filt, pop};
      if (wr_en_in && !filt && full) overflow <= 1'b1;
`else
      credit_out <= pop;
      if (wr_en_in && full) overflow <= 1'b1;
`endif
      case (state)
        ST_IDLE: begin
          if (pop) begin
            data_out <= head;
            if (GAP != 0) begin
              state   <= ST_GAP;
              gap_cnt <= GAP_LOAD;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) state <= ST_IDLE;
          else gap_cnt <= gap_cnt - GAP_W'(1);
        end
      endcase
    end
  end

endmodule
